uart_imem_loader: RTL and testbench
===================================

// Module: uart_imem_loader
// PURPOSE
//  Boot-time sequencer between the UART receiver and the instruction memory.
//  Packs received bytes (LSB first) into 32-bit words and writes them to consecutive IMEM
//  word addresses. Holds the core in reset until the terminator word 32'hFFFFFFFF arrives,
//  then releases the core and raises write_done.
// PARAMETERS
//  ADDR_W       8        IMEM word-address width; capacity DEPTH = 2**ADDR_W words
//  TERM_WORD    32'hFFFFFFFF  end-of-program marker (never written to IMEM)
//  GAP_CYC      200000   inter-byte timeout in clk cycles (used only with LOADER_GAP_TIMEOUT_EN)
// PORTS
//  clk            in   1       system clock
//  resetn         in   1       asynchronous active-low reset
//  uart_rx_valid  in   1       1-cycle strobe: uart_rx_data holds a new byte
//  uart_rx_data   in   8       received byte
//  uart_rx_break  in   1       1-cycle strobe: BREAK seen on line
//  imem_wr_en     out  1       IMEM write strobe, 1 cycle per word
//  imem_wr_addr   out  ADDR_W  IMEM word address
//  imem_wr_data   out  32      IMEM write data
//  cpu_rst        out  1       active-high core reset; 1 until load complete
//  write_done     out  1       sticky: program loaded
//  load_ovf       out  1       sticky: words arrived beyond DEPTH and were dropped
// BEHAVIOUR
//  - Reset values: imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, cpu_rst=1, write_done=0,
//    load_ovf=0; byte index=0, state=LOAD.
//  - States: LOAD (collect bytes), WRITE (issue 1-cycle write), DONE (terminal).
//  - LOAD: each uart_rx_valid shifts the byte into lane [8*idx +: 8], idx++ (2-bit, wraps).
//    4th byte (idx==3): full word formed. If word==TERM_WORD -> DONE next cycle; else
//    -> WRITE next cycle.
//  - WRITE: imem_wr_en=1 for exactly 1 cycle with data/addr stable; addr increments the cycle
//    after. Return to LOAD. Latency: 4th uart_rx_valid at cycle N -> imem_wr_en at N+1.
//    A uart_rx_valid arriving during WRITE is accepted into the next word (no byte loss).
//  - Capacity: once DEPTH words are written, further non-terminator words are dropped
//    (no imem_wr_en), load_ovf set; addr saturates at DEPTH-1 and does not wrap.
//  - Terminator: entering DONE sets write_done=1 and cpu_rst=0 in the same cycle (N+1).
//    TERM_WORD is not written. DONE ignores all UART inputs until resetn.
//  - uart_rx_break in LOAD: discard the partial word (idx=0). Break and valid in the same
//    cycle: break wins, byte discarded. Break in WRITE: current write completes; partial
//    next word discarded.
//  - resetn low mid-word or mid-write: immediate return to reset values; the IMEM contents
//    already written are not cleared by this block.
// CONFIGURATION
//  LOADER_GAP_TIMEOUT_EN defined: a counter clears on each uart_rx_valid; if idx!=0 and
//    GAP_CYC cycles elapse with no byte, the partial word is discarded (idx=0), as for a
//    break. Not defined: no counter; a partial word waits indefinitely.
// STRUCTURE
//  loader_pkg: state enum {LOAD,WRITE,DONE}, TERM_WORD default, WORD_BYTES=4.
//  Sub-module loader_word_packer: byte shift lanes + 2-bit index + clear input;
//    outputs word and word_ready strobe. FSM, address and flags in top.
// TESTING
//  1. Send bytes 13,01,01,FD then FF x4 -> one write addr 0 data FD010113; write_done=1,
//     cpu_rst=0 at the cycle after the last FF byte.
//  2. Three words then terminator -> writes to addr 0,1,2 in order; no write for the marker.
//  3. Send 2 bytes, pulse uart_rx_break, send 23,26,81,02 -> single write data 02812623.
//  4. ADDR_W=2: send 5 words + terminator -> 4 writes (addr 0..3), load_ovf=1, write_done=1.
//  5. Drop resetn after 2 bytes of word 3 -> all outputs at reset values; reload from addr 0.
//  6. With LOADER_GAP_TIMEOUT_EN and GAP_CYC=100: 1 byte, idle 150 cycles, 4 bytes AA,BB,CC,DD
//     -> write data DDCCBBAA; without the macro, the same stimulus writes data CCBBAA<first>.

Source files
------------

// File: rtl/uart_imem_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_imem_loader_pkg : shared types/constants for the IMEM loader  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } loader_state_e;

  localparam logic [31:0] TERM_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int unsigned WORD_BYTES        = 4;
  localparam int unsigned IDX_W             = $clog2(WORD_BYTES);

endpackage
`default_nettype wire

// File: rtl/uart_imem_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_imem_loader_if : UART byte stream in, IMEM write port out     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface uart_imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              uart_rx_valid;
  logic [7:0]        uart_rx_data;
  logic              uart_rx_break;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [31:0]       imem_wr_data;

  modport master (
    input  uart_rx_valid, uart_rx_data, uart_rx_break,
    output imem_wr_en, imem_wr_addr, imem_wr_data
  );

  modport slave (
    output uart_rx_valid, uart_rx_data, uart_rx_break,
    input  imem_wr_en, imem_wr_addr, imem_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/uart_imem_loader_word_packer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | loader_word_packer : packs UART bytes LSB-first into 32-bit words  |
// | Option macro: LOADER_GAP_TIMEOUT_EN (inter-byte gap flush)         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module loader_word_packer
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned GAP_CYC = 200000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_ready
);
  localparam int unsigned      LANE_W   = 8 * (WORD_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  logic [LANE_W-1:0] lanes_q, lanes_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              flush;
  logic              take;

`ifdef LOADER_GAP_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

  logic [GAP_W-1:0] gap_q, gap_d;
  logic             gap_expired;

  // A byte landing on the expiry cycle is not a gap, so it is kept.
  assign gap_expired = (idx_q != '0) && !byte_valid && (gap_q == GAP_W'(GAP_CYC));
  assign flush       = clear | gap_expired;

  always_comb begin
    gap_d = gap_q;
    if (byte_valid || idx_q == '0) begin
      gap_d = '0;
    end else if (gap_q != GAP_W'(GAP_CYC)) begin
      gap_d = gap_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  assign flush = clear;
`endif

  assign take       = byte_valid & ~flush;
  assign word       = {byte_data, lanes_q};
  assign word_ready = take && (idx_q == LAST_IDX);

  always_comb begin
    lanes_d = lanes_q;
    idx_d   = idx_q;
    if (flush) begin
      idx_d = '0;
    end else if (take) begin
      idx_d = idx_q + 1'b1;
    end
    // The top lane is never stored: it is taken straight from byte_data.
    for (int unsigned i = 0; i < WORD_BYTES - 1; i++) begin
      if (take && idx_q == IDX_W'(i)) begin
        lanes_d[8*i +: 8] = byte_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lanes_q <= '0;
      idx_q   <= '0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_imem_loader : boot loader, UART bytes -> IMEM words, then     |
// | releases core reset on the terminator word.                        |
// | Option macro: LOADER_GAP_TIMEOUT_EN (handled in the word packer)   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] TERM_WORD = TERM_WORD_DEFAULT,
  parameter int unsigned GAP_CYC   = 200000
) (
  input  logic                clk,
  input  logic                resetn,
  uart_imem_loader_if.master  bus,
  output logic                cpu_rst,
  output logic                write_done,
  output logic                load_ovf
);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;

  logic              rx_live;
  logic [31:0]       word;
  logic              word_ready;
  logic              is_term;

  assign rx_live = (state_q != ST_DONE);
  assign is_term = (word == TERM_WORD);

  loader_word_packer #(
    .GAP_CYC (GAP_CYC)
  ) u_packer (
    .clk        (clk),
    .resetn     (resetn),
    .byte_valid (bus.uart_rx_valid & rx_live),
    .byte_data  (bus.uart_rx_data),
    .clear      (bus.uart_rx_break & rx_live),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // full_d already reflects a write retiring this cycle at the last address.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD, ST_WRITE: begin
        state_d = ST_LOAD;
        if (word_ready) begin
          if (is_term) begin
            state_d = ST_DONE;
          end else if (!full_d) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    full_d = full_q;
    ovf_d  = ovf_q;
    if (state_q == ST_WRITE) begin
      if (addr_q == ADDR_MAX) begin
        full_d = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
    if (word_ready && !is_term) begin
      if (full_d) begin
        ovf_d = 1'b1;
      end else begin
        data_d = word;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      data_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    bus.imem_wr_en   = (state_q == ST_WRITE);
    bus.imem_wr_addr = addr_q;
    bus.imem_wr_data = data_q;
    cpu_rst          = (state_q != ST_DONE);
    write_done       = (state_q == ST_DONE);
    load_ovf         = ovf_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_uart_imem_loader : directed self-checking bench for the loader  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_uart_imem_loader;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_valid = 1'b0;
  logic       rx_break = 1'b0;
  logic [7:0] rx_data = 8'h00;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  uart_imem_loader_if #(.ADDR_W(8)) bus_a ();
  uart_imem_loader_if #(.ADDR_W(2)) bus_b ();

  assign bus_a.uart_rx_valid = rx_valid;
  assign bus_a.uart_rx_data  = rx_data;
  assign bus_a.uart_rx_break = rx_break;
  assign bus_b.uart_rx_valid = rx_valid;
  assign bus_b.uart_rx_data  = rx_data;
  assign bus_b.uart_rx_break = rx_break;

  logic a_cpu_rst, a_done, a_ovf;
  logic b_cpu_rst, b_done, b_ovf;

  uart_imem_loader #(.ADDR_W(8), .TERM_WORD(32'hFFFF_FFFF), .GAP_CYC(100)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus_a),
    .cpu_rst    (a_cpu_rst),
    .write_done (a_done),
    .load_ovf   (a_ovf)
  );

  uart_imem_loader #(.ADDR_W(2), .TERM_WORD(32'hFFFF_FFFF), .GAP_CYC(100)) dut_small (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus_b),
    .cpu_rst    (b_cpu_rst),
    .write_done (b_done),
    .load_ovf   (b_ovf)
  );

  // Write logs, captured mid-cycle while the strobe is stable.
  int          a_cnt = 0;
  int          b_cnt = 0;
  logic [7:0]  a_addr [16];
  logic [31:0] a_data [16];
  logic [1:0]  b_addr [16];
  logic [31:0] b_data [16];

  always @(negedge clk) begin
    if (!resetn) begin
      a_cnt = 0;
      b_cnt = 0;
    end else begin
      if (bus_a.imem_wr_en === 1'b1) begin
        if (a_cnt < 16) begin
          a_addr[a_cnt] = bus_a.imem_wr_addr;
          a_data[a_cnt] = bus_a.imem_wr_data;
        end
        a_cnt++;
      end
      if (bus_b.imem_wr_en === 1'b1) begin
        if (b_cnt < 16) begin
          b_addr[b_cnt] = bus_b.imem_wr_addr;
          b_data[b_cnt] = bus_b.imem_wr_data;
        end
        b_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_byte_brk(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_break = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_break = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_break();
    @(negedge clk);
    rx_break = 1'b1;
    @(negedge clk);
    rx_break = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  logic [31:0] t2_words [3];

  initial begin
    t2_words[0] = 32'h0000_0093;
    t2_words[1] = 32'h1234_5678;
    t2_words[2] = 32'hDEAD_BEEF;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_wr_en",   {31'd0, bus_a.imem_wr_en}, 32'd0);
    chk("rst_wr_addr", {24'd0, bus_a.imem_wr_addr}, 32'd0);
    chk("rst_wr_data", bus_a.imem_wr_data, 32'd0);
    chk("rst_cpu_rst", {31'd0, a_cpu_rst}, 32'd1);
    chk("rst_done",    {31'd0, a_done}, 32'd0);
    chk("rst_ovf",     {31'd0, a_ovf}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // T1: single word then terminator, exact latencies
    send_byte(8'h13);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'hFD);
    chk("t1_wr_en",   {31'd0, bus_a.imem_wr_en}, 32'd1);
    chk("t1_wr_addr", {24'd0, bus_a.imem_wr_addr}, 32'd0);
    chk("t1_wr_data", bus_a.imem_wr_data, 32'hFD01_0113);
    @(negedge clk);
    chk("t1_wr_en_1cyc", {31'd0, bus_a.imem_wr_en}, 32'd0);
    chk("t1_addr_inc",   {24'd0, bus_a.imem_wr_addr}, 32'd1);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hFF);
    chk("t1_done_early", {31'd0, a_done}, 32'd0);
    send_byte(8'hFF);
    chk("t1_done",       {31'd0, a_done}, 32'd1);
    chk("t1_cpu_rst",    {31'd0, a_cpu_rst}, 32'd0);
    chk("t1_no_term_wr", {31'd0, bus_a.imem_wr_en}, 32'd0);
    settle(2);
    chk("t1_wr_cnt", 32'(a_cnt), 32'd1);

    // T2: three words in order, terminator not written, DONE ignores input
    do_reset();
    for (int i = 0; i < 3; i++) send_word(t2_words[i]);
    send_word(32'hFFFF_FFFF);
    settle(2);
    chk("t2_wr_cnt", 32'(a_cnt), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_addr", {24'd0, a_addr[i]}, 32'(i));
      chk("t2_data", a_data[i], t2_words[i]);
    end
    chk("t2_done", {31'd0, a_done}, 32'd1);
    send_word(32'h1122_3344);
    settle(2);
    chk("t2_done_ignores", 32'(a_cnt), 32'd3);
    chk("t2_cpu_rst_held", {31'd0, a_cpu_rst}, 32'd0);

    // T3: break discards partial word; break beats a same-cycle byte
    do_reset();
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_break();
    send_byte(8'h23);
    send_byte(8'h26);
    send_byte(8'h81);
    send_byte(8'h02);
    chk("t3_wr_en",   {31'd0, bus_a.imem_wr_en}, 32'd1);
    chk("t3_wr_data", bus_a.imem_wr_data, 32'h0281_2623);
    chk("t3_wr_addr", {24'd0, bus_a.imem_wr_addr}, 32'd0);
    send_byte(8'h77);
    send_byte_brk(8'h55);
    send_word(32'h0403_0201);
    chk("t3_brk_valid_data", bus_a.imem_wr_data, 32'h0403_0201);
    chk("t3_brk_valid_addr", {24'd0, bus_a.imem_wr_addr}, 32'd1);
    settle(2);
    chk("t3_wr_cnt", 32'(a_cnt), 32'd2);

    // T4: capacity 4 words, fifth dropped, address saturates
    do_reset();
    for (int i = 1; i <= 4; i++) send_word(32'(i));
    settle(1);
    chk("t4_ovf_not_yet", {31'd0, b_ovf}, 32'd0);
    send_word(32'd5);
    settle(1);
    chk("t4_ovf",       {31'd0, b_ovf}, 32'd1);
    chk("t4_addr_sat",  {30'd0, bus_b.imem_wr_addr}, 32'd3);
    send_word(32'hFFFF_FFFF);
    settle(2);
    chk("t4_wr_cnt", 32'(b_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_addr", {30'd0, b_addr[i]}, 32'(i));
      chk("t4_data", b_data[i], 32'(i + 1));
    end
    chk("t4_done",    {31'd0, b_done}, 32'd1);
    chk("t4_cpu_rst", {31'd0, b_cpu_rst}, 32'd0);

    // T5: reset in the middle of a word, then reload from address 0
    do_reset();
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    send_word(32'h0000_0003);
    send_byte(8'h44);
    send_byte(8'h55);
    #1;
    chk("t5_addr_pre", {24'd0, bus_a.imem_wr_addr}, 32'd3);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("t5_rst_wr_en",   {31'd0, bus_a.imem_wr_en}, 32'd0);
    chk("t5_rst_wr_addr", {24'd0, bus_a.imem_wr_addr}, 32'd0);
    chk("t5_rst_wr_data", bus_a.imem_wr_data, 32'd0);
    chk("t5_rst_cpu_rst", {31'd0, a_cpu_rst}, 32'd1);
    chk("t5_rst_done",    {31'd0, a_done}, 32'd0);
    chk("t5_rst_ovf",     {31'd0, a_ovf}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    send_word(32'hCAFE_F00D);
    chk("t5_reload_en",   {31'd0, bus_a.imem_wr_en}, 32'd1);
    chk("t5_reload_addr", {24'd0, bus_a.imem_wr_addr}, 32'd0);
    chk("t5_reload_data", bus_a.imem_wr_data, 32'hCAFE_F00D);

    // T6: long idle after one byte
    do_reset();
    send_byte(8'h11);
    settle(150);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
`ifdef LOADER_GAP_TIMEOUT_EN
    chk("t6_no_early_wr", {31'd0, bus_a.imem_wr_en}, 32'd0);
    send_byte(8'hDD);
    chk("t6_wr_en",   {31'd0, bus_a.imem_wr_en}, 32'd1);
    chk("t6_wr_data", bus_a.imem_wr_data, 32'hDDCC_BBAA);
`else
    chk("t6_wr_en",   {31'd0, bus_a.imem_wr_en}, 32'd1);
    chk("t6_wr_data", bus_a.imem_wr_data, 32'hCCBB_AA11);
    send_byte(8'hDD);
`endif
    settle(2);
    chk("t6_wr_cnt", 32'(a_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
